// File: rtl/osc_pkg.sv
// Shared oscilloscope types and constants used by trigger_capture and trigger_rom.
package osc_pkg;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 512;

  typedef enum logic [2:0] {
    FILL,
    ARMED,
    POST,
    REQ,
    ACK,
    XFER
  } capture_state_t;

endpackage

// File: rtl/trigger_detect.sv
// Combinational threshold-crossing compare for the selected slope.
module trigger_detect
  import osc_pkg::*;
#(
  parameter int DATA_W = osc_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] prev,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] threshold,
  input  logic              slope,
  output logic              hit
);

  // slope = 1 looks for a falling crossing, otherwise rising
  always_comb begin
    if (slope) hit = (prev >= threshold) && (sample < threshold);
    else       hit = (prev < threshold) && (sample >= threshold);
  end

endmodule

// File: rtl/trigger_capture.sv
// Acquisition front-end: shift buffer, pre-trigger fill, slope trigger,
// post-trigger collection and read/ready handoff to trigger_rom.
// Optional feature: define TRIG_AUTO_EN to force a trigger after
// AUTO_TIMEOUT valid samples spent in ARMED.
//
// state | meaning
// FILL  | collecting the pre-trigger window
// ARMED | watching each sample for a threshold crossing
// POST  | collecting the samples after the trigger
// REQ   | buffer frozen, waiting for ready to issue read
// ACK   | read issued, waiting for ready to drop
// XFER  | responder copying, waiting for ready to return
module trigger_capture
  import osc_pkg::*;
#(
  parameter int DATA_W       = osc_pkg::DATA_W,
  parameter int DEPTH        = osc_pkg::DEPTH,
  parameter int PRETRIG      = 128,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] threshold,
  input  logic              slope,
  input  logic              ready,
  output logic              read,
  output logic [DATA_W-1:0] data [0:DEPTH-1],
  output logic              triggered,
  output logic              hold
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int POST_N = DEPTH - PRETRIG - 1;

  // terminal compares fire on the last counted sample; END values are the saturated counts
  localparam logic [CNT_W-1:0] FILL_TC  = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0] FILL_END = CNT_W'(PRETRIG);
  localparam logic [CNT_W-1:0] POST_TC  = (POST_N > 0) ? CNT_W'(POST_N - 1) : '0;
  localparam logic [CNT_W-1:0] POST_END = CNT_W'(POST_N);

  capture_state_t   state;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] post_cnt;
  logic             hit;
  logic             auto_fire;
  logic             fire;
  logic             shift_en;

  trigger_detect #(.DATA_W(DATA_W)) u_detect (
    .prev      (data[DEPTH-1]),
    .sample    (sample),
    .threshold (threshold),
    .slope     (slope),
    .hit       (hit)
  );

  assign shift_en = sample_valid && ((state == FILL) || (state == ARMED) || (state == POST));
  assign fire     = sample_valid && (state == ARMED) && (hit || auto_fire);

`ifdef TRIG_AUTO_EN
  localparam int AUTO_W = $clog2(AUTO_TIMEOUT) + 1;
  localparam logic [AUTO_W-1:0] AUTO_TC = AUTO_W'(AUTO_TIMEOUT);

  logic [AUTO_W-1:0] auto_cnt;

  assign auto_fire = (auto_cnt == AUTO_TC);

  // ARMED sample counter; held at zero outside ARMED so every entry starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         auto_cnt <= '0;
    else if (state != ARMED)            auto_cnt <= '0;
    else if (sample_valid && !auto_fire) auto_cnt <= auto_cnt + 1'b1;
  end
`else
  logic unused_auto;
  assign auto_fire   = 1'b0;
  assign unused_auto = (AUTO_TIMEOUT > 0);
`endif

  // sample shift register; oldest sample at index 0, frozen outside FILL/ARMED/POST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < DEPTH - 1; i++) data[i] <= data[i+1];
      data[DEPTH-1] <= sample;
    end
  end

  // capture sequencing and registered read/triggered/hold outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      read      <= 1'b0;
      triggered <= 1'b0;
      hold      <= 1'b0;
    end else begin
      read      <= 1'b0;
      triggered <= 1'b0;
      case (state)
        FILL: begin
          if (sample_valid) begin
            if (fill_cnt == FILL_TC) begin
              fill_cnt <= FILL_END;
              state    <= ARMED;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        ARMED: begin
          if (fire) begin
            triggered <= 1'b1;
            post_cnt  <= '0;
            if (POST_N == 0) begin
              hold  <= 1'b1;
              state <= REQ;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (sample_valid) begin
            if (post_cnt == POST_TC) begin
              post_cnt <= POST_END;
              hold     <= 1'b1;
              state    <= REQ;
            end else begin
              post_cnt <= post_cnt + 1'b1;
            end
          end
        end
        REQ: begin
          if (ready) begin
            read  <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          if (!ready) state <= XFER;
        end
        XFER: begin
          if (ready) begin
            fill_cnt <= '0;
            post_cnt <= '0;
            hold     <= 1'b0;
            state    <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
